// File: rtl/prog_loader.sv
// Program loader and run sequencer: streams a memory image into CPU RAM from
// address 0 with the CPU held in reset, then releases it for a fixed run and captures r1.
module prog_loader #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 10,
  parameter int RST_CYCLES = 2,
  parameter int RUN_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W:0]   load_len,
  input  logic [RUN_W-1:0]  run_cycles,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_reset,
  input  logic [DATA_W-1:0] result_in,
  output logic [DATA_W-1:0] result,
  output logic              done,
  output logic              busy,
  output logic              err_overflow
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RC_W-1:0] RST_LAST = RC_W'(RST_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RST,
    S_RUN,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic                s_ready_q, s_ready_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                cpu_reset_q, cpu_reset_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    len_q, len_d;
  logic [RUN_W-1:0]    run_len_q, run_len_d;
  logic [CNT_W-1:0]    wcnt_q, wcnt_d;
  logic [RC_W-1:0]     rcnt_q, rcnt_d;
  logic [RUN_W-1:0]    run_cnt_q, run_cnt_d;
  logic                xfer;
  logic                ovf;

  always_comb begin
    // NOTE: every signal gets a default before any branch; a path that leaves
    // one unassigned would infer a latch instead of holding the flop value.
    state_d     = state_q;
    s_ready_d   = s_ready_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_reset_d = cpu_reset_q;
    result_d    = result_q;
    done_d      = done_q;
    busy_d      = busy_q;
    err_d       = err_q;
    len_d       = len_q;
    run_len_d   = run_len_q;
    wcnt_d      = wcnt_q;
    rcnt_d      = rcnt_q;
    run_cnt_d   = run_cnt_q;
    xfer        = s_valid & s_ready_q;
    ovf         = load_len > DEPTH;

    if (abort) begin
      // Abort drops any word offered this cycle; result and RAM are left alone.
      state_d     = S_IDLE;
      cpu_reset_d = 1'b1;
      s_ready_d   = 1'b0;
      busy_d      = 1'b0;
      done_d      = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            run_len_d   = run_cycles;
            err_d       = ovf;
            len_d       = ovf ? DEPTH : load_len;
            done_d      = 1'b0;
            busy_d      = 1'b1;
            wcnt_d      = '0;
            rcnt_d      = '0;
            cpu_reset_d = 1'b1;
            if (load_len == '0) begin
              state_d = S_RST;
            end else begin
              state_d   = S_LOAD;
              s_ready_d = 1'b1;
            end
          end
        end

        S_LOAD: begin
          if (xfer) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = wcnt_q[ADDR_W-1:0];
            mem_wdata_d = s_data;
            wcnt_d      = wcnt_q + 1'b1;
            if (wcnt_q == len_q - 1'b1) begin
              s_ready_d = 1'b0;
              state_d   = S_RST;
            end
          end
        end

        S_RST: begin
          // The final write pulse occupies the first RST cycle and is not counted.
          if (!mem_we_q) begin
            if (rcnt_q == RST_LAST) begin
              cpu_reset_d = 1'b0;
              run_cnt_d   = '0;
              state_d     = S_RUN;
            end else begin
              rcnt_d = rcnt_q + 1'b1;
            end
          end
        end

        S_RUN: begin
          if (run_cnt_q == run_len_q) begin
            result_d = result_in;
            done_d   = 1'b1;
            busy_d   = 1'b0;
            state_d  = S_DONE;
          end else begin
            run_cnt_d = run_cnt_q + 1'b1;
          end
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      s_ready_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_reset_q <= 1'b1;
      result_q    <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      len_q       <= '0;
      run_len_q   <= '0;
      wcnt_q      <= '0;
      rcnt_q      <= '0;
      run_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      s_ready_q   <= s_ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_reset_q <= cpu_reset_d;
      result_q    <= result_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      len_q       <= len_d;
      run_len_q   <= run_len_d;
      wcnt_q      <= wcnt_d;
      rcnt_q      <= rcnt_d;
      run_cnt_q   <= run_cnt_d;
    end
  end

  assign s_ready      = s_ready_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign cpu_reset    = cpu_reset_q;
  assign result       = result_q;
  assign done         = done_q;
  assign busy         = busy_q;
  assign err_overflow = err_q;

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Hardware program loader and run sequencer for the CPU and its external RAM.
- Accepts a memory image over a valid/ready word stream and writes it into RAM from address 0 while holding the CPU in reset.
- Then pulses reset for a fixed length, lets the CPU run a programmed number of cycles, and captures the CPU result register (r1).
- Replaces the readmemb / reset-cycle / fixed-delay sequence with a synthesizable, parametrised block usable on the board and in benches.

Parameters:
DATA_W, 16, RAM word and stream width
ADDR_W, 10, RAM address width; depth = 2^ADDR_W words
RST_CYCLES, 2, cycles cpu_reset is held after the last write before release (>=1)
RUN_W, 16, width of the run-cycle counter

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle request to begin load/run; ignored while busy=1
abort  in  1  synchronous abort; returns to IDLE from any state
load_len  in  ADDR_W+1  number of words to load, sampled on start
run_cycles  in  RUN_W  CPU run cycles before capture, sampled on start
s_valid  in  1  stream word valid
s_data  in  DATA_W  stream word
s_ready  out  1  loader accepts a word this cycle
mem_we  out  1  RAM write enable, one-cycle pulse per word
mem_addr  out  ADDR_W  RAM write address
mem_wdata  out  DATA_W  RAM write data
cpu_reset  out  1  active-high reset to CPU
result_in  in  DATA_W  CPU r1
result  out  DATA_W  captured r1
done  out  1  result valid (level)
busy  out  1  high in LOAD, RST, RUN
err_overflow  out  1  sticky: load_len exceeded depth

Behaviour:
- All outputs are registered.
- Reset (reset=0, async):
  - state=IDLE; cpu_reset=1.
  - s_ready, mem_we, done, busy, err_overflow = 0.
  - mem_addr, mem_wdata, result = 0.
  - All counters = 0.
- IDLE:
  - start=1: latch run_cycles; latch len = min(load_len, 2^ADDR_W).
  - If load_len > 2^ADDR_W: err_overflow<=1. It clears only on the next accepted start or on reset.
  - done<=0, busy<=1, word counter<=0, cpu_reset stays 1.
  - len=0 goes to RST; otherwise goes to LOAD with s_ready<=1.
- LOAD:
  - Transfer occurs on an edge where s_valid & s_ready.
  - Next cycle: mem_we=1, mem_addr=counter, mem_wdata=s_data. Counter increments.
  - s_valid=0 inserts gaps with no writes. s_ready stays 1 until the final word.
  - Final word (counter==len-1): s_ready<=0 on the same edge, then go to RST.
  - Final write pulse lands in the first RST cycle.
  - Counter is ADDR_W+1 bits. Address wraps never occur because len is clipped.
- RST:
  - cpu_reset held 1 for RST_CYCLES cycles, counted from the cycle after the final mem_we pulse. With len=0, counted from RST entry.
  - Then cpu_reset<=0, run counter<=0, go to RUN.
- RUN:
  - Run counter increments every cycle cpu_reset=0.
  - When counter==run_cycles: result<=result_in, done<=1, busy<=0, go to DONE.
  - result therefore samples r1 after exactly run_cycles cycles with cpu_reset low. run_cycles=0 captures on the first RUN cycle.
- DONE:
  - cpu_reset stays 0 (CPU keeps running); result is frozen.
  - start behaves as in IDLE (new load, done cleared).
- abort:
  - Valid in any state, takes priority over start and over a same-cycle stream transfer (that word is dropped).
  - Next state IDLE; cpu_reset<=1; s_ready, mem_we, busy, done <= 0.
  - result retains its last value. RAM contents already written are not undone.
- start while busy=1 is ignored. start and abort in the same cycle: abort wins.
- Async reset mid-LOAD: any write pulse in flight is cancelled immediately (mem_we=0).

Test Plan:
- Basic load/run: reset, start with load_len=3, run_cycles=5, stream 0x0011, 0x0022, 0x0033 back-to-back, result_in=0x00E9 -> mem_we pulses at addresses 0,1,2 with those data; cpu_reset high through 2 cycles after last pulse, then low; done=1 and result=0x00E9 exactly 5 cycles later.
- Stream gaps: load_len=4, s_valid toggling 1,0,0,1,1,0,1 -> exactly 4 writes at addresses 0..3 with correct data; no write on idle cycles; s_ready=0 after 4th transfer.
- Boundaries: load_len=0, run_cycles=0 -> no mem_we; cpu_reset released after RST_CYCLES; result captured on first RUN cycle. load_len=1025 with ADDR_W=10 -> err_overflow=1; 1024 writes, last at address 1023.
- Abort mid-load: load_len=8, abort after 3rd transfer while s_valid=1 -> 3 writes only, state IDLE, cpu_reset=1, busy=0, done=0; a new start proceeds normally and clears err_overflow.
- Ignored/priority: start pulsed during RUN -> no effect on counters or result. start and abort in the same cycle in IDLE -> remains IDLE.
- Async reset during RUN (reset low mid-cycle) -> outputs go to reset values immediately without waiting for clk; cpu_reset=1.
